// File: rtl/box_pkg.sv
// Shared types and constants for the box triangle emitter.
package box_pkg;

    // Faces in emission order; the value doubles as the face_mask bit index.
    typedef enum logic [2:0] {
        FACE_FRONT  = 3'd0,
        FACE_LEFT   = 3'd1,
        FACE_RIGHT  = 3'd2,
        FACE_TOP    = 3'd3,
        FACE_BOTTOM = 3'd4,
        FACE_BACK   = 3'd5
    } face_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Corner select: xsel 0=L 1=R, ysel 0=T 1=B, zsel 0=N 1=F.
    typedef struct packed {
        logic xsel;
        logic ysel;
        logic zsel;
    } corner_sel_t;

    // Returned by first_face_from when no enabled face remains.
    localparam logic [2:0] NO_FACE = 3'd6;

    localparam logic [15:0] DEF_COL_FRONT  = 16'h0400;
    localparam logic [15:0] DEF_COL_LEFT   = 16'h0200;
    localparam logic [15:0] DEF_COL_RIGHT  = 16'h0200;
    localparam logic [15:0] DEF_COL_TOP    = 16'h1404;
    localparam logic [15:0] DEF_COL_BOTTOM = 16'h2204;
    localparam logic [15:0] DEF_COL_BACK   = 16'h0400;

    // Lowest enabled face index that is >= from, or NO_FACE.
    function automatic logic [2:0] first_face_from(input logic [5:0] mask, input logic [2:0] from);
        logic [2:0] found;
        found = NO_FACE;
        for (int i = 5; i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) begin
                found = 3'(i);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/box_emitter_if.sv
// Vertex stream between the box emitter and the rasteriser triangle input.
interface box_emitter_if;
    logic [47:0] vertex;
    logic [15:0] color;
    logic        new_triangle;
    logic        vertex_valid;
    logic        vertex_ready;

    modport master (
        output vertex,
        output color,
        output new_triangle,
        output vertex_valid,
        input  vertex_ready
    );

    modport slave (
        input  vertex,
        input  color,
        input  new_triangle,
        input  vertex_valid,
        output vertex_ready
    );
endinterface

// File: rtl/box_face_lut.sv
// Combinational map from (face, vertex index) to the box corner to emit.
module box_face_lut
    import box_pkg::*;
(
    input  face_t       face,
    input  logic [2:0]  idx,
    output corner_sel_t sel
);

    logic [2:0] pat;

    // Each face pair shares one pattern; the pair member flips a single axis.
    always_comb begin
        pat = 3'b000;
        case (face)
            FACE_FRONT, FACE_BACK: begin
                case (idx)
                    3'd1:    pat = 3'b100;
                    3'd2:    pat = 3'b010;
                    3'd3:    pat = 3'b010;
                    3'd4:    pat = 3'b100;
                    3'd5:    pat = 3'b110;
                    default: pat = 3'b000;
                endcase
                pat[0] = (face == FACE_BACK);
            end
            FACE_LEFT, FACE_RIGHT: begin
                case (idx)
                    3'd1:    pat = 3'b010;
                    3'd2:    pat = 3'b011;
                    3'd3:    pat = 3'b011;
                    3'd4:    pat = 3'b001;
                    default: pat = 3'b000;
                endcase
                pat[2] = (face == FACE_RIGHT);
            end
            FACE_TOP, FACE_BOTTOM: begin
                case (idx)
                    3'd1:    pat = 3'b100;
                    3'd2:    pat = 3'b101;
                    3'd3:    pat = 3'b101;
                    3'd4:    pat = 3'b001;
                    default: pat = 3'b000;
                endcase
                pat[1] = (face == FACE_BOTTOM);
            end
            default: pat = 3'b000;
        endcase
        sel = corner_sel_t'(pat);
    end

endmodule

// File: rtl/box_emitter.sv
// Streams the triangles of an axis-aligned box, two per enabled face.
module box_emitter
    import box_pkg::*;
#(
    parameter int          BOX_W      = 32,
    parameter int          BOX_H      = 32,
    parameter int          BOX_D      = 32,
    parameter int          NUM_LANES  = 3,
    parameter int          LANE_PITCH = 96,
    parameter int          Z_OFFSET   = 64,
    parameter logic [15:0] COL_FRONT  = DEF_COL_FRONT,
    parameter logic [15:0] COL_LEFT   = DEF_COL_LEFT,
    parameter logic [15:0] COL_RIGHT  = DEF_COL_RIGHT,
    parameter logic [15:0] COL_TOP    = DEF_COL_TOP,
    parameter logic [15:0] COL_BOTTOM = DEF_COL_BOTTOM,
    parameter logic [15:0] COL_BACK   = DEF_COL_BACK,
    localparam int         LW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LW-1:0]       lane,
    input  logic signed [15:0]  height,
    input  logic signed [15:0]  z_front,
    input  logic [5:0]          face_mask,
    box_emitter_if.master       tri_if,
    output logic                busy,
    output logic                done
);

    localparam logic signed [15:0] HALF_LANES = 16'((NUM_LANES - 1) / 2);
    localparam logic signed [15:0] PITCH      = 16'(LANE_PITCH);
    localparam logic signed [15:0] HALF_W     = 16'(BOX_W / 2);
    localparam logic signed [15:0] SIZE_H     = 16'(BOX_H);
    localparam logic signed [15:0] SIZE_D     = 16'(BOX_D);
    localparam logic signed [15:0] ZOFF       = 16'(Z_OFFSET);

    state_t             state_q, state_d;
    face_t              face_q, face_d;
    logic [2:0]         vidx_q, vidx_d;
    logic [5:0]         mask_q, mask_d;
    logic signed [15:0] left_q, left_d, right_q, right_d;
    logic signed [15:0] top_q, top_d, bot_q, bot_d;
    logic signed [15:0] near_q, near_d, far_q, far_d;
    logic [47:0]        vertex_q, vertex_d;
    logic [15:0]        color_q, color_d;
    logic               new_tri_q, new_tri_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LW-1:0]      lane_cl;
    logic signed [15:0] lane_s, centre;
    logic signed [15:0] in_left, in_right, in_top, in_bot, in_near, in_far;
    logic               handshake, last_vertex, load_vertex;
    logic [2:0]         next_face_after;
    corner_sel_t        sel;

    function automatic logic [15:0] face_color(input face_t f);
        case (f)
            FACE_FRONT:  return COL_FRONT;
            FACE_LEFT:   return COL_LEFT;
            FACE_RIGHT:  return COL_RIGHT;
            FACE_TOP:    return COL_TOP;
            FACE_BOTTOM: return COL_BOTTOM;
            FACE_BACK:   return COL_BACK;
            default:     return 16'h0000;
        endcase
    endfunction

    assign handshake       = valid_q && tri_if.vertex_ready;
    assign next_face_after = first_face_from(mask_q, 3'(face_q) + 3'd1);
    assign last_vertex     = (vidx_q == 3'd5) && (next_face_after == NO_FACE);

    // Box extents from the live inputs, used only on the cycle a start is taken.
    always_comb begin
        lane_cl = lane;
        if (32'(lane) >= NUM_LANES) begin
            lane_cl = LW'(NUM_LANES - 1);
        end
        lane_s   = 16'(lane_cl);
        centre   = (lane_s - HALF_LANES) * PITCH;
        in_left  = centre - HALF_W;
        in_right = centre + HALF_W;
        in_top   = -height;
        in_bot   = -height - SIZE_H;
        in_near  = z_front + ZOFF;
        in_far   = z_front + SIZE_D + ZOFF;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: an empty mask jumps straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (face_mask == 6'd0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (handshake && last_vertex) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stream position and latched geometry; disabled faces are skipped in the same step.
    always_comb begin
        face_d  = face_q;
        vidx_d  = vidx_q;
        mask_d  = mask_q;
        left_d  = left_q;
        right_d = right_q;
        top_d   = top_q;
        bot_d   = bot_q;
        near_d  = near_q;
        far_d   = far_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = face_mask;
                    left_d  = in_left;
                    right_d = in_right;
                    top_d   = in_top;
                    bot_d   = in_bot;
                    near_d  = in_near;
                    far_d   = in_far;
                    vidx_d  = 3'd0;
                    if (face_mask != 6'd0) begin
                        face_d = face_t'(first_face_from(face_mask, 3'd0));
                    end
                end
            end
            EMIT: begin
                if (handshake && !last_vertex) begin
                    if (vidx_q == 3'd5) begin
                        face_d = face_t'(next_face_after);
                        vidx_d = 3'd0;
                    end else begin
                        vidx_d = vidx_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    box_face_lut u_lut (
        .face (face_d),
        .idx  (vidx_d),
        .sel  (sel)
    );

    // Registered outputs; the vertex only changes on start or on a handshake.
    always_comb begin
        vertex_d    = vertex_q;
        color_d     = color_q;
        new_tri_d   = new_tri_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_vertex = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (face_mask == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        load_vertex = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (last_vertex) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load_vertex = 1'b1;
                    end
                end
            end
            DONE:    busy_d = 1'b0;
            default: ;
        endcase
        if (load_vertex) begin
            valid_d   = 1'b1;
            vertex_d  = {sel.xsel ? right_d : left_d,
                         sel.ysel ? bot_d   : top_d,
                         sel.zsel ? far_d   : near_d};
            color_d   = face_color(face_d);
            new_tri_d = (vidx_d == 3'd0) || (vidx_d == 3'd3);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            face_q    <= FACE_FRONT;
            vidx_q    <= 3'd0;
            mask_q    <= 6'd0;
            left_q    <= '0;
            right_q   <= '0;
            top_q     <= '0;
            bot_q     <= '0;
            near_q    <= '0;
            far_q     <= '0;
            vertex_q  <= '0;
            color_q   <= '0;
            new_tri_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            face_q    <= face_d;
            vidx_q    <= vidx_d;
            mask_q    <= mask_d;
            left_q    <= left_d;
            right_q   <= right_d;
            top_q     <= top_d;
            bot_q     <= bot_d;
            near_q    <= near_d;
            far_q     <= far_d;
            vertex_q  <= vertex_d;
            color_q   <= color_d;
            new_tri_q <= new_tri_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tri_if.vertex       = vertex_q;
    assign tri_if.color        = color_q;
    assign tri_if.new_triangle = new_tri_q;
    assign tri_if.vertex_valid = valid_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_box_emitter.sv
// Self-checking bench for box_emitter against a coordinate-level reference model.
module tb_box_emitter;

    typedef struct packed {
        logic [47:0] v;
        logic [15:0] c;
        logic        nt;
    } vtx_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [1:0]         lane;
    logic signed [15:0] height;
    logic signed [15:0] z_front;
    logic [5:0]         face_mask;
    logic               busy;
    logic               done;

    int tests_run;
    int tests_failed;

    vtx_t exp_q[$];
    vtx_t got_q[$];
    vtx_t saved_q[$];

    box_emitter_if tri_bus ();

    box_emitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lane      (lane),
        .height    (height),
        .z_front   (z_front),
        .face_mask (face_mask),
        .tri_if    (tri_bus),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vtx_t mk(input int x, input int y, input int z, input logic [15:0] col, input bit nt);
        vtx_t t;
        t.v  = {16'(x), 16'(y), 16'(z)};
        t.c  = col;
        t.nt = nt;
        return t;
    endfunction

    task automatic add_face(input logic [15:0] col, input int xs[6], input int ys[6], input int zs[6]);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(xs[i], ys[i], zs[i], col, (i == 0) || (i == 3)));
        end
    endtask

    // Expected stream from the box corners; int arithmetic truncated to 16 bits gives the wrap.
    task automatic build_model(input int ln, input int ht, input int zf, input logic [5:0] m);
        int lc, c, l, r, t, b, n, f;
        lc = (ln > 2) ? 2 : ln;
        c  = (lc - 1) * 96;
        l  = c - 16;
        r  = c + 16;
        t  = -ht;
        b  = -ht - 32;
        n  = zf + 64;
        f  = zf + 32 + 64;
        exp_q.delete();
        if (m[0]) add_face(16'h0400, '{l, r, l, l, r, r}, '{t, t, b, b, t, b}, '{n, n, n, n, n, n});
        if (m[1]) add_face(16'h0200, '{l, l, l, l, l, l}, '{t, b, b, b, t, t}, '{n, n, f, f, f, n});
        if (m[2]) add_face(16'h0200, '{r, r, r, r, r, r}, '{t, b, b, b, t, t}, '{n, n, f, f, f, n});
        if (m[3]) add_face(16'h1404, '{l, r, r, r, l, l}, '{t, t, t, t, t, t}, '{n, n, f, f, f, n});
        if (m[4]) add_face(16'h2204, '{l, r, r, r, l, l}, '{b, b, b, b, b, b}, '{n, n, f, f, f, n});
        if (m[5]) add_face(16'h0400, '{l, r, l, l, r, r}, '{f == f ? t : t, t, b, b, t, b}, '{f, f, f, f, f, f});
    endtask

    // One start-to-done run; reset_at >= 0 pulls rst_n after that many handshakes.
    task automatic run_stream(input string name, input logic [1:0] ln, input logic signed [15:0] ht,
                              input logic signed [15:0] zf, input logic [5:0] m,
                              input bit rnd_ready, input bit poke_start, input int reset_at);
        int   cycle;
        int   idx;
        bit   done_seen;
        bit   stalled;
        bit   saw_done;
        vtx_t held;
        vtx_t cur;
        build_model(int'(ln), int'(ht), int'(zf), m);
        got_q.delete();
        @(negedge clk);
        lane      = ln;
        height    = ht;
        z_front   = zf;
        face_mask = m;
        start     = 1'b1;
        tri_bus.vertex_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        lane      = 2'($urandom);
        height    = 16'($urandom);
        z_front   = 16'($urandom);
        face_mask = 6'($urandom);
        cycle     = 1;
        stalled   = 1'b0;
        done_seen = 1'b0;
        held      = '0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s busy_rise: got %b want 1", name, busy);
        end
        while (!done_seen) begin
            if (cycle > 400) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s timeout: no done within 400 cycles, %0d handshakes", name, got_q.size());
                break;
            end
            cur = '{tri_bus.vertex, tri_bus.color, tri_bus.new_triangle};
            if (reset_at >= 0 && got_q.size() == reset_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                tests_run++;
                if (tri_bus.vertex_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s reset_flush: valid/busy/done got %b%b%b want 000",
                             name, tri_bus.vertex_valid, busy, done);
                end
                rst_n    = 1'b1;
                saw_done = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (done !== 1'b0 || tri_bus.vertex_valid !== 1'b0) saw_done = 1'b1;
                end
                tests_run++;
                if (saw_done) begin
                    tests_failed++;
                    $display("[TB] FAIL %s reset_no_done: got activity after reset want none", name);
                end
                return;
            end
            if (stalled) begin
                tests_run++;
                if (tri_bus.vertex_valid !== 1'b1 || cur !== held) begin
                    tests_failed++;
                    $display("[TB] FAIL %s stall_hold: got valid=%b %h want valid=1 %h",
                             name, tri_bus.vertex_valid, cur, held);
                end
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                tests_run++;
                if (got_q.size() != exp_q.size() || tri_bus.vertex_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s count_at_done: got %0d handshakes valid=%b want %0d valid=0",
                             name, got_q.size(), tri_bus.vertex_valid, exp_q.size());
                end
                tests_run++;
                if (busy !== (m == 6'd0)) begin
                    tests_failed++;
                    $display("[TB] FAIL %s busy_at_done: got %b want %b", name, busy, (m == 6'd0));
                end
                if (!rnd_ready) begin
                    tests_run++;
                    if (cycle != exp_q.size() + 1) begin
                        tests_failed++;
                        $display("[TB] FAIL %s done_cycle: got %0d want %0d", name, cycle, exp_q.size() + 1);
                    end
                end
                if (poke_start) begin
                    start     = 1'b1;
                    face_mask = 6'b111111;
                    @(negedge clk);
                    start = 1'b0;
                    tests_run++;
                    if (busy !== 1'b0 || tri_bus.vertex_valid !== 1'b0) begin
                        tests_failed++;
                        $display("[TB] FAIL %s start_in_done: busy=%b valid=%b want 0 0",
                                 name, busy, tri_bus.vertex_valid);
                    end
                end
            end else begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL %s busy_hold: cycle %0d got %b want 1", name, cycle, busy);
                end
                tri_bus.vertex_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tri_bus.vertex_valid === 1'b1 && tri_bus.vertex_ready) begin
                    got_q.push_back(cur);
                    idx = got_q.size() - 1;
                    tests_run++;
                    if (idx >= exp_q.size()) begin
                        tests_failed++;
                        $display("[TB] FAIL %s extra_vertex: got %h at %0d want only %0d",
                                 name, cur, idx, exp_q.size());
                    end else if (cur !== exp_q[idx]) begin
                        tests_failed++;
                        $display("[TB] FAIL %s vertex[%0d]: got %h want %h", name, idx, cur, exp_q[idx]);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = (tri_bus.vertex_valid === 1'b1);
                    held    = cur;
                end
                if (poke_start) start = 1'($urandom_range(0, 1));
                @(negedge clk);
                cycle++;
            end
        end
        start = 1'b0;
        tri_bus.vertex_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tri_bus.vertex !== 48'd0 || tri_bus.color !== 16'd0 || tri_bus.new_triangle !== 1'b0 ||
            tri_bus.vertex_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got v=%h c=%h nt=%b val=%b busy=%b done=%b want all 0",
                     tri_bus.vertex, tri_bus.color, tri_bus.new_triangle, tri_bus.vertex_valid, busy, done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_stream();
        run_stream("default", 2'd1, 16'sd0, 16'sd176, 6'b011111, 1'b0, 1'b0, -1);
        tests_run++;
        if (got_q.size() != 30) begin
            tests_failed++;
            $display("[TB] FAIL default_count: got %0d want 30", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0].v !== {16'hFFF0, 16'h0000, 16'd240} || got_q[0].c !== 16'h0400) begin
                tests_failed++;
                $display("[TB] FAIL default_first: got %h/%h want fff00000_00f0/0400", got_q[0].v, got_q[0].c);
            end
            tests_run++;
            if (got_q[29].v !== {16'hFFF0, 16'hFFE0, 16'd240} || got_q[29].c !== 16'h2204) begin
                tests_failed++;
                $display("[TB] FAIL default_last: got %h/%h want fff0ffe000f0/2204", got_q[29].v, got_q[29].c);
            end
        end
    endtask

    task automatic test_back_face();
        int nts;
        bit bad;
        run_stream("back", 2'd0, 16'sd0, 16'sd176, 6'b100000, 1'b0, 1'b0, -1);
        nts = 0;
        bad = 1'b0;
        foreach (got_q[i]) begin
            if (got_q[i].nt) nts++;
            if (got_q[i].nt !== ((i == 0) || (i == 3))) bad = 1'b1;
            if (got_q[i].v[15:0] !== 16'd272) bad = 1'b1;
            if (got_q[i].v[47:32] !== 16'hFF90 && got_q[i].v[47:32] !== 16'hFFB0) bad = 1'b1;
        end
        tests_run++;
        if (bad || nts != 2 || got_q.size() != 6) begin
            tests_failed++;
            $display("[TB] FAIL back_face: got %0d vertices %0d new_triangle bad=%b want 6, 2, 0",
                     got_q.size(), nts, bad);
        end
    endtask

    task automatic test_backpressure();
        run_stream("full_ready", 2'd2, 16'sd40, -16'sd20, 6'b111111, 1'b0, 1'b0, -1);
        saved_q = got_q;
        run_stream("full_random", 2'd2, 16'sd40, -16'sd20, 6'b111111, 1'b1, 1'b0, -1);
        tests_run++;
        if (got_q != saved_q || got_q.size() != 36) begin
            tests_failed++;
            $display("[TB] FAIL stall_sequence: got %0d vertices want 36 identical to ready-high run", got_q.size());
        end
    endtask

    task automatic test_empty_mask();
        run_stream("empty", 2'd1, 16'sd5, 16'sd5, 6'b000000, 1'b0, 1'b0, -1);
    endtask

    task automatic test_lane_clamp();
        bit bad;
        run_stream("clamp", 2'd3, 16'sh7FF0, 16'sd100, 6'b111111, 1'b0, 1'b0, -1);
        bad = 1'b0;
        foreach (got_q[i]) begin
            if (got_q[i].v[47:32] !== 16'd80 && got_q[i].v[47:32] !== 16'd112) bad = 1'b1;
        end
        tests_run++;
        if (bad || got_q.size() != 36) begin
            tests_failed++;
            $display("[TB] FAIL lane_clamp_x: got %0d vertices bad=%b want 36 with x in 80/112", got_q.size(), bad);
        end
    endtask

    task automatic test_reset_mid_run();
        run_stream("mid_reset", 2'd1, 16'sd0, 16'sd176, 6'b111111, 1'b0, 1'b0, 10);
        run_stream("after_reset", 2'd0, 16'sd12, 16'sd30, 6'b111111, 1'b1, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            run_stream("random", 2'($urandom), 16'($urandom), 16'($urandom), 6'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        lane         = 2'd0;
        height       = 16'sd0;
        z_front      = 16'sd0;
        face_mask    = 6'd0;
        tri_bus.vertex_ready = 1'b1;
        test_reset();
        test_default_stream();
        test_back_face();
        test_backpressure();
        test_empty_mask();
        test_lane_clamp();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/box_emitter.md
# box_emitter

Parametrised successor to the single-box player sprite generator. On a one-cycle `start`, it latches a lane, base height and front depth. It then streams the triangles of an axis-aligned box into the rasteriser's triangle input, two triangles per enabled face, under a valid/ready handshake. Box size, lane geometry, depth and per-face colours are parameters, and a run-time face mask allows culling hidden faces, including the back face.

## Interface
Parameters:
- `BOX_W`, default 32: box width in x (positive, even).
- `BOX_H`, default 32: box height in y (positive).
- `BOX_D`, default 32: box depth in z (positive).
- `NUM_LANES`, default 3: lane count (odd, ≥1).
- `LANE_PITCH`, default 96: distance between lane centres in x.
- `Z_OFFSET`, default 64: added to every emitted z.
- `COL_FRONT`, `COL_LEFT`, `COL_RIGHT`, `COL_TOP`, `COL_BOTTOM`, `COL_BACK`, defaults 16'h0400, 16'h0200, 16'h0200, 16'h1404, 16'h2204, 16'h0400: per-face colour.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `lane` in LW (`$clog2(NUM_LANES)`, min 1): lane index; values ≥ NUM_LANES clamp to NUM_LANES−1.
- `height` in 16 signed: base height; box top y = −height.
- `z_front` in 16 signed: near-face depth before offset.
- `face_mask` in 6: bit order {back, bottom, top, right, left, front}; 1 = emit the face.
- `vertex` out 48: {x, y, z+Z_OFFSET}, each 16-bit signed.
- `color` out 16: colour of the current face.
- `new_triangle` out 1: high on the first vertex of each triangle.
- `vertex_valid` out 1: `vertex`, `color` and `new_triangle` are valid.
- `vertex_ready` in 1: downstream accepts the vertex on `vertex_valid && vertex_ready`.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse when the run completes.

## Operation
- Geometry:
  - lane centre c = (lane − (NUM_LANES−1)/2)·LANE_PITCH.
  - L = c − BOX_W/2, R = c + BOX_W/2.
  - T = −height, B = −height − BOX_H.
  - N = z_front, F = z_front + BOX_D.
  - All arithmetic is 16-bit signed and wraps on overflow; no saturation.
- On start in IDLE: latch lane (after clamping), height, z_front and face_mask; go to EMIT. Inputs are ignored after this point.
- Faces are visited in fixed order front, left, right, top, bottom, back. Faces with a mask bit of 0 are skipped with no cycle penalty.
- Six vertices per face:
  - front (N): LTN, RTN, LBN, LBN, RTN, RBN.
  - back: the front pattern with F instead of N.
  - left: LTN, LBN, LBF, LBF, LTF, LTN.
  - right: the left pattern with R instead of L.
  - top: LTN, RTN, RTF, RTF, LTF, LTN.
  - bottom: the top pattern with B instead of T.
- `color` equals the face colour for all six of its vertices. `new_triangle` is high on vertex indices 0 and 3 of each face.
- States:
  - IDLE: start → EMIT; if face_mask == 0, go to DONE instead.
  - EMIT: advance on each handshake; after the last vertex of the last enabled face is accepted → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- Reset values: state IDLE. `vertex`, `color`, `vertex_valid`, `new_triangle`, `busy` and `done` are all 0.

## Timing
- All outputs are registered.
- Start accepted at cycle 0 → first vertex valid and busy = 1 at cycle 1.
- With `vertex_ready` held high, one vertex is accepted per cycle, 6·popcount(mask) cycles in total. `done` pulses the cycle after the last acceptance, and `busy` falls in that same cycle.
- Backpressure: while `vertex_valid && !vertex_ready`, `vertex`, `color` and `new_triangle` hold stable. `vertex_valid` never drops without a handshake.
- `start` while busy or in DONE is ignored and not queued.
- face_mask == 0: no vertex is emitted; `busy` and `done` are both high at cycle 1.
- `rst_n` low mid-run: the next cycle is IDLE with `vertex_valid` = 0. The partial stream is discarded and no `done` is produced.
- Start in the cycle after `done` is accepted.

## Structure
- Package `box_pkg` holds:
  - the face enum (FACE_FRONT … FACE_BACK) and state enum (IDLE, EMIT, DONE);
  - the corner-select encoding {xsel, ysel, zsel};
  - the default colour constants.
- Sub-module `box_face_lut` is purely combinational: (face, vertex index 0–5) → corner-select bits. The top level maps those selects to the latched L/R/T/B/N/F values.

## Test plan
- Default parameters, lane=1, height=0, z_front=176, mask=6'b011111, ready high → 30 vertices. First vertex {−16, 0, 240} with color 16'h0400. Last vertex {−16, −32, 240} with color 16'h2204. `done` at cycle 31.
- lane=0, mask=6'b100000 → 6 vertices at z=272 (208+64), x ∈ {−112, −80}, new_triangle on the 1st and 4th vertex only.
- Random `vertex_ready` (50%) on a full-mask run → 36 handshakes, outputs stable during stalls, sequence identical to the ready-high run.
- mask=0 → no `vertex_valid` at any point; `done` pulses at cycle 1.
- lane=3 with NUM_LANES=3 → same x values as lane=2 (80/112). height=16'h7FF0 → y wraps per 16-bit arithmetic.
- `rst_n` low at vertex 10 → `vertex_valid` = 0 the next cycle, no `done`. A new start then produces a full, correct stream; start pulses during busy have no effect.
